// File: rtl/key_blend_pkg.sv
// Shared constants, fade FSM state type and key helpers for key_blend_pipe.
// Optional rounding is enabled with KEY_BLEND_ROUND_EN (see key_blend_lane).
package key_blend_pkg;

    localparam int DEF_DATA_W = 10;
    localparam int DEF_KEY_W  = 10;
    localparam int DEF_CH     = 3;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        HOLD
    } fade_state_t;

    function automatic int unsigned kmax(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/key_blend_pipe_if.sv
// Pixel, key and fade-control bundle between a pixel source and key_blend_pipe.
// Widths are set by the instance parameters and must match the pipe.
interface key_blend_pipe_if #(
    parameter int DATA_W = 10,
    parameter int KEY_W  = 10,
    parameter int CH     = 3
);
    logic                 in_valid;
    logic [CH*DATA_W-1:0] data_in_a;
    logic [CH*DATA_W-1:0] data_in_b;
    logic [KEY_W-1:0]     key_in;
    logic                 key_mode;
    logic                 frame_start;
    logic                 fade_start;
    logic                 fade_dir;
    logic [KEY_W-1:0]     fade_step;
    logic                 out_valid;
    logic [CH*DATA_W-1:0] data_out;
    logic                 fade_busy;

    modport master (
        output in_valid, data_in_a, data_in_b, key_in, key_mode,
        output frame_start, fade_start, fade_dir, fade_step,
        input  out_valid, data_out, fade_busy
    );

    modport slave (
        input  in_valid, data_in_a, data_in_b, key_in, key_mode,
        input  frame_start, fade_start, fade_dir, fade_step,
        output out_valid, data_out, fade_busy
    );
endinterface

// File: rtl/key_blend_lane.sv
// One channel of the blend: S2 products, S3 sum/shift/output register.
// KEY_BLEND_ROUND_EN adds half an LSB before the shift (round-half-up).
module key_blend_lane
    import key_blend_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int KEY_W  = DEF_KEY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en2,
    input  logic              en3,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [KEY_W-1:0]  k,
    output logic [DATA_W-1:0] q
);
    localparam int PW = DATA_W + KEY_W;
    localparam logic [KEY_W-1:0] KMAX = KEY_W'(kmax(KEY_W));
`ifdef KEY_BLEND_ROUND_EN
    localparam logic [PW-1:0] RND = PW'(1) << (KEY_W - 1);
`else
    localparam logic [PW-1:0] RND = '0;
`endif

    logic [PW-1:0] pa;
    logic [PW-1:0] pb;
    logic [PW-1:0] sum;

    always_ff @(posedge clk) begin
        if (en2) begin
            pa <= PW'(a) * PW'(k);
            pb <= PW'(b) * PW'(KMAX - k);
        end
    end

    // a*k + b*(KMAX-k) + RND < 2^PW, so the sum never wraps
    assign sum = pa + pb + RND;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en3) begin
            q <= sum[PW-1:KEY_W];
        end
    end
endmodule

// File: rtl/key_blend_pipe.sv
// 3-stage keyed blend of two pixels with an internal frame-stepped fade key.
// Rounding instead of truncation is selected with KEY_BLEND_ROUND_EN.
module key_blend_pipe
    import key_blend_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int KEY_W  = DEF_KEY_W,
    parameter int CH     = DEF_CH
) (
    input logic            clk,
    input logic            rst,
    key_blend_pipe_if.slave bus
);
    localparam logic [KEY_W-1:0] KMAX = KEY_W'(kmax(KEY_W));

    fade_state_t          state;
    logic [KEY_W-1:0]     fade_key;
    logic [KEY_W-1:0]     step_r;
    logic                 dir_r;
    logic                 fade_busy;
    logic [KEY_W:0]       up_sum;

    logic                 v1;
    logic                 v2;
    logic                 v3;
    logic [CH*DATA_W-1:0] a1;
    logic [CH*DATA_W-1:0] b1;
    logic [KEY_W-1:0]     k1;
    logic [CH*DATA_W-1:0] dout;

    assign up_sum = {1'b0, fade_key} + {1'b0, step_r};

    // fade_start takes priority over a coincident frame_start
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fade_key  <= '0;
            step_r    <= '0;
            dir_r     <= 1'b0;
            fade_busy <= 1'b0;
        end else if (bus.fade_start) begin
            dir_r     <= bus.fade_dir;
            step_r    <= (bus.fade_step == '0) ? KEY_W'(1) : bus.fade_step;
            if (state == IDLE) begin
                fade_key <= bus.fade_dir ? '0 : KMAX;
            end
            state     <= RAMP;
            fade_busy <= 1'b1;
        end else if (bus.frame_start && state == RAMP) begin
            unique case (1'b1)
                dir_r && (up_sum >= {1'b0, KMAX}): begin
                    fade_key  <= KMAX;
                    state     <= HOLD;
                    fade_busy <= 1'b0;
                end
                dir_r && (up_sum < {1'b0, KMAX}): begin
                    fade_key <= up_sum[KEY_W-1:0];
                end
                !dir_r && (fade_key <= step_r): begin
                    fade_key  <= '0;
                    state     <= HOLD;
                    fade_busy <= 1'b0;
                end
                default: begin
                    fade_key <= fade_key - step_r;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= bus.in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            a1 <= bus.data_in_a;
            b1 <= bus.data_in_b;
            k1 <= bus.key_mode ? fade_key : bus.key_in;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        key_blend_lane #(
            .DATA_W(DATA_W),
            .KEY_W (KEY_W)
        ) u_lane (
            .clk(clk),
            .rst(rst),
            .en2(v1),
            .en3(v2),
            .a  (a1[c*DATA_W +: DATA_W]),
            .b  (b1[c*DATA_W +: DATA_W]),
            .k  (k1),
            .q  (dout[c*DATA_W +: DATA_W])
        );
    end

    assign bus.out_valid = v3;
    assign bus.data_out  = dout;
    assign bus.fade_busy = fade_busy;
endmodule

// File: tb/tb_key_blend_pipe.sv
// Scoreboard bench for key_blend_pipe: reference blend/fade model feeds a queue,
// a negedge monitor pops and compares every presented pixel.
module tb_key_blend_pipe;
    import key_blend_pkg::*;

    localparam int DW = 10;
    localparam int KW = 10;
    localparam int CH = 3;
    localparam int KM = 1023;
`ifdef KEY_BLEND_ROUND_EN
    localparam int RND = 512;
`else
    localparam int RND = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_blend_pipe_if #(.DATA_W(DW), .KEY_W(KW), .CH(CH)) ifc ();

    key_blend_pipe #(.DATA_W(DW), .KEY_W(KW), .CH(CH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    typedef struct {
        logic [CH*DW-1:0] d;
        int               c;
    } exp_t;

    exp_t             q[$];
    int               n_chk = 0;
    int               n_fail = 0;
    int               cyc = 0;
    bit               mon_en = 0;
    logic [CH*DW-1:0] last_out = '0;

    // reference fade model: key value, whether ramping, whether a fade ever started
    int mkey = 0;
    bit mramp = 0;
    bit mstarted = 0;
    bit mup = 0;
    int mstep = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (ifc.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("data_out", ifc.data_out, e.d);
                    chk("latency", cyc, e.c + 3);
                    last_out = e.d;
                end
            end else begin
                chk("hold", {ifc.out_valid, ifc.data_out}, {1'b0, last_out});
            end
        end
    end

    task automatic model_apply();
        exp_t e;
        int k, a, b;
        if (rst) begin
            q.delete();
            last_out = '0;
            mkey = 0; mramp = 0; mstarted = 0; mup = 0; mstep = 1;
        end else begin
            if (ifc.in_valid) begin
                k = ifc.key_mode ? mkey : int'(ifc.key_in);
                for (int c = 0; c < CH; c++) begin
                    a = int'(ifc.data_in_a[c*DW +: DW]);
                    b = int'(ifc.data_in_b[c*DW +: DW]);
                    e.d[c*DW +: DW] = DW'((a * k + b * (KM - k) + RND) / 1024);
                end
                e.c = cyc;
                q.push_back(e);
            end
            if (ifc.fade_start) begin
                mup = ifc.fade_dir;
                mstep = (ifc.fade_step == 0) ? 1 : int'(ifc.fade_step);
                if (!mstarted) mkey = ifc.fade_dir ? 0 : KM;
                mstarted = 1;
                mramp = 1;
            end else if (ifc.frame_start && mramp) begin
                if (mup) begin
                    mkey = (mkey + mstep >= KM) ? KM : mkey + mstep;
                    if (mkey == KM) mramp = 0;
                end else begin
                    mkey = (mkey - mstep <= 0) ? 0 : mkey - mstep;
                    if (mkey == 0) mramp = 0;
                end
            end
        end
    endtask

    // one clock: model sees the inputs just before the sampling edge
    task automatic step();
        @(negedge clk);
        #1;
        model_apply();
        @(posedge clk);
        #1;
        chk("fade_busy", ifc.fade_busy, mramp);
        chk("fade_key", dut.fade_key, mkey);
        ifc.in_valid = 0;
        ifc.frame_start = 0;
        ifc.fade_start = 0;
        rst = 0;
    endtask

    task automatic set_pix(input int a, input int b);
        ifc.in_valid = 1;
        for (int c = 0; c < CH; c++) begin
            ifc.data_in_a[c*DW +: DW] = DW'(a);
            ifc.data_in_b[c*DW +: DW] = DW'(b);
        end
    endtask

    task automatic rand_pix();
        ifc.in_valid = 1;
        for (int c = 0; c < CH; c++) begin
            ifc.data_in_a[c*DW +: DW] = DW'($urandom_range(0, KM));
            ifc.data_in_b[c*DW +: DW] = DW'($urandom_range(0, KM));
        end
    endtask

    initial begin
        int exp_k[4];
        bit pat[7];
        exp_k = '{256, 512, 768, 1023};
        pat = '{1, 1, 0, 1, 0, 0, 1};
        ifc.in_valid = 0; ifc.data_in_a = '0; ifc.data_in_b = '0;
        ifc.key_in = '0; ifc.key_mode = 0; ifc.frame_start = 0;
        ifc.fade_start = 0; ifc.fade_dir = 0; ifc.fade_step = '0;

        rst = 1; step();
        rst = 1; step();
        mon_en = 1;
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_data_out", ifc.data_out, 0);
        chk("rst_state", dut.state, IDLE);

        // full key passes foreground
        ifc.key_in = 10'd1023; set_pix(1000, 0); step();
        step();
        chk("lat_not_yet", ifc.out_valid, 0);
        step();
        chk("full_key_valid", ifc.out_valid, 1);
        chk("full_key_data", ifc.data_out, {3{10'd999}});

        ifc.key_in = 10'd512; set_pix(800, 200); step();
        step(); step();
`ifdef KEY_BLEND_ROUND_EN
        chk("half_key_data", ifc.data_out, {3{10'd500}});
`else
        chk("half_key_data", ifc.data_out, {3{10'd499}});
`endif

        ifc.key_in = 10'($urandom_range(0, KM));
        for (int i = 0; i < 7; i++) begin
            if (pat[i]) rand_pix();
            step();
        end
        repeat (4) step();

        // fade ramp up in 256 steps, observed through pixels with a=max, b=0
        ifc.key_mode = 1;
        ifc.fade_start = 1; ifc.fade_dir = 1; ifc.fade_step = 10'd256;
        step();
        chk("fade_start_key", dut.fade_key, 0);
        for (int i = 0; i < 4; i++) begin
            ifc.frame_start = 1; set_pix(1023, 0); step();
            chk("fade_ramp_key", dut.fade_key, exp_k[i]);
        end
        chk("fade_hold_state", dut.state, HOLD);
        chk("fade_hold_busy", ifc.fade_busy, 0);
        set_pix(1023, 0); step();

        // fade_start wins over a coincident frame_start
        ifc.fade_start = 1; ifc.frame_start = 1; ifc.fade_dir = 0; ifc.fade_step = 10'd100;
        step();
        chk("coincident_key", dut.fade_key, 1023);
        ifc.frame_start = 1; step();
        chk("down_step_key", dut.fade_key, 923);

        // reset mid-ramp with pixels in flight
        rand_pix(); step();
        rand_pix(); step();
        rand_pix(); rst = 1; step();
        chk("flush_valid", ifc.out_valid, 0);
        chk("flush_data", ifc.data_out, 0);
        chk("flush_key", dut.fade_key, 0);
        chk("flush_state", dut.state, IDLE);
        repeat (5) step();

        for (int i = 0; i < 500; i++) begin
            ifc.key_mode = 1'($urandom_range(0, 1));
            ifc.key_in = 10'($urandom_range(0, KM));
            if ($urandom_range(0, 1) == 1) rand_pix();
            ifc.frame_start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 24) == 0) begin
                ifc.fade_start = 1;
                ifc.fade_dir = 1'($urandom_range(0, 1));
                ifc.fade_step = ($urandom_range(0, 3) == 0) ? '0 : 10'($urandom_range(1, 300));
            end
            rst = ($urandom_range(0, 149) == 0);
            step();
        end

        repeat (6) step();
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
